// File: rtl/qpu_mcu_measure_collect.sv
// Collects per-qubit readout strobes for one measurement request and emits a single
// registered write toward the result register, either on full coverage or on timeout.
module qpu_mcu_measure_collect #(
    parameter int unsigned QUBIT_NUM = 12,
    parameter int unsigned TIMEOUT   = 1000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 meas_req_valid,
    input  logic [QUBIT_NUM-1:0] meas_req_list,
    output logic                 meas_req_ready,
    input  logic [QUBIT_NUM-1:0] rd_i_valid,
    input  logic [QUBIT_NUM-1:0] rd_i_data,
    output logic                 mcu_measure_o_wen,
    output logic [QUBIT_NUM-1:0] mcu_measure_o_data,
    output logic [QUBIT_NUM-1:0] mcu_measure_o_list,
    output logic                 mcu_timeout_o,
    output logic                 busy
);

    localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE,
        COLLECT,
        ISSUE
    } state_t;

    state_t               state_q, state_d;
    logic [QUBIT_NUM-1:0] pend_q, pend_d;
    logic [QUBIT_NUM-1:0] got_q, got_d;
    logic [QUBIT_NUM-1:0] dat_q, dat_d;
    logic [15:0]          cnt_q, cnt_d;
    logic                 wen_q, wen_d;
    logic [QUBIT_NUM-1:0] odata_q, odata_d;
    logic [QUBIT_NUM-1:0] olist_q, olist_d;
    logic                 otmo_q, otmo_d;
    logic [QUBIT_NUM-1:0] accept_bits;
    logic [QUBIT_NUM-1:0] got_all;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            pend_q  <= '0;
            got_q   <= '0;
            dat_q   <= '0;
            cnt_q   <= '0;
            wen_q   <= 1'b0;
            odata_q <= '0;
            olist_q <= '0;
            otmo_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            got_q   <= got_d;
            dat_q   <= dat_d;
            cnt_q   <= cnt_d;
            wen_q   <= wen_d;
            odata_q <= odata_d;
            olist_q <= olist_d;
            otmo_q  <= otmo_d;
        end
    end

    // Outputs are loaded on the edge entering ISSUE so they are valid exactly for that state.
    always_comb begin
        state_d     = state_q;
        pend_d      = pend_q;
        got_d       = got_q;
        dat_d       = dat_q;
        cnt_d       = cnt_q;
        wen_d       = 1'b0;
        odata_d     = '0;
        olist_d     = '0;
        otmo_d      = 1'b0;
        accept_bits = rd_i_valid & pend_q & ~got_q;
        got_all     = got_q | accept_bits;

        unique case (state_q)
            IDLE: begin
                if (meas_req_valid && (meas_req_list != '0)) begin
                    pend_d  = meas_req_list;
                    got_d   = '0;
                    dat_d   = '0;
                    cnt_d   = '0;
                    state_d = COLLECT;
                end
            end
            COLLECT: begin
                got_d = got_all;
                dat_d = dat_q | (accept_bits & rd_i_data);
                // Completion is tested first so a last strobe on the final cycle is not a timeout.
                if (got_all == pend_q) begin
                    state_d = ISSUE;
                    wen_d   = 1'b1;
                    odata_d = dat_d & pend_q;
                    olist_d = pend_q;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ISSUE;
                    wen_d   = 1'b1;
                    odata_d = dat_d & pend_q;
                    olist_d = pend_q;
                    otmo_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            ISSUE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign meas_req_ready     = (state_q == IDLE);
    assign busy               = (state_q != IDLE);
    assign mcu_measure_o_wen  = wen_q;
    assign mcu_measure_o_data = odata_q;
    assign mcu_measure_o_list = olist_q;
    assign mcu_timeout_o      = otmo_q;

endmodule
